// File: rtl/lut_neuron_loader_if.sv
// Config-stream and lookup bus for lut_neuron_loader.
// Optional macro LUT_CKSUM_EN adds the cfg_cksum signal.
interface lut_neuron_loader_if #(
    parameter int unsigned IN_BITS  = 8,
    parameter int unsigned OUT_BITS = 2,
    parameter int unsigned CFG_W    = 8
);
    logic                load_start;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CFG_W-1:0]    cfg_data;
    logic                cfg_last;
    logic                loaded;
    logic                load_err;
    logic                M0_valid;
    logic [IN_BITS-1:0]  M0;
    logic                M1_valid;
    logic [OUT_BITS-1:0] M1;
`ifdef LUT_CKSUM_EN
    logic [7:0]          cfg_cksum;
`endif

    // Upstream side: drives config beats and lookup requests
    modport master (
        output
`ifdef LUT_CKSUM_EN
               cfg_cksum,
`endif
               load_start, cfg_valid, cfg_data, cfg_last, M0_valid, M0,
        input  cfg_ready, loaded, load_err, M1_valid, M1
    );

    // Loader side
    modport slave (
        input
`ifdef LUT_CKSUM_EN
               cfg_cksum,
`endif
               load_start, cfg_valid, cfg_data, cfg_last, M0_valid, M0,
        output cfg_ready, loaded, load_err, M1_valid, M1
    );
endinterface

// File: rtl/lut_neuron_loader.sv
// Runtime-loadable LUT neuron: a config stream fills a distributed-RAM truth
// table, and the datapath reads it back with one cycle of latency.
// Optional macro LUT_CKSUM_EN enables an 8-bit running-sum check of each load.
module lut_neuron_loader #(
    parameter int unsigned IN_BITS  = 8,
    parameter int unsigned OUT_BITS = 2,
    parameter int unsigned CFG_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    lut_neuron_loader_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** IN_BITS;
    localparam int unsigned EPB   = CFG_W / OUT_BITS;
    localparam int unsigned NB    = DEPTH / EPB;
    localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB - 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    beat_cnt;
    logic                cfg_ready_q;
    logic                loaded_q;
    logic                load_err_q;
    logic                m1_valid_q;
    logic [OUT_BITS-1:0] m1_q;
    logic [OUT_BITS-1:0] mem [DEPTH];

    logic write_c;
    logic frame_end_c;
    logic good_c;
    logic err_c;
    logic lookup_c;
    logic cksum_ok_c;

`ifdef LUT_CKSUM_EN
    logic [7:0] cksum_ref;
    logic [7:0] cksum_acc;
`endif

    // Beat acceptance, framing checks and next-state decode
    always_comb begin
        state_nxt   = state;
        write_c     = 1'b0;
        frame_end_c = 1'b0;
        good_c      = 1'b0;
        err_c       = 1'b0;
        lookup_c    = 1'b0;
        cksum_ok_c  = 1'b1;
`ifdef LUT_CKSUM_EN
        cksum_ok_c  = ((cksum_acc + 8'(bus.cfg_data)) == cksum_ref);
`endif
        // load_start wins over a coincident beat, which is then dropped
        write_c     = bus.cfg_valid && (state == LOADING) && !bus.load_start && !rst;
        frame_end_c = write_c && (bus.cfg_last || (beat_cnt == LAST_CNT));
        good_c      = frame_end_c && bus.cfg_last && (beat_cnt == LAST_CNT) && cksum_ok_c;
        err_c       = frame_end_c && !good_c;
        lookup_c    = bus.M0_valid && (state == READY);

        if (bus.load_start) begin
            state_nxt = LOADING;
        end else begin
            case (state)
                LOADING: begin
                    if (good_c) begin
                        state_nxt = READY;
                    end else if (err_c) begin
                        state_nxt = EMPTY;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered status flags, beat counter and lookup result
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ready_q <= 1'b0;
            loaded_q    <= 1'b0;
            load_err_q  <= 1'b0;
            beat_cnt    <= '0;
            m1_valid_q  <= 1'b0;
            m1_q        <= '0;
        end else begin
            cfg_ready_q <= (state_nxt == LOADING);
            loaded_q    <= (state_nxt == READY);
            if (bus.load_start) begin
                load_err_q <= 1'b0;
            end else if (err_c) begin
                load_err_q <= 1'b1;
            end
            if (bus.load_start) begin
                beat_cnt <= '0;
            end else if (write_c) begin
                beat_cnt <= frame_end_c ? '0 : beat_cnt + CNT_W'(1);
            end
            m1_valid_q <= lookup_c;
            if (lookup_c) begin
                m1_q <= mem[bus.M0];
            end
        end
    end

`ifdef LUT_CKSUM_EN
    // Expected checksum capture and running sum of accepted beats
    always_ff @(posedge clk) begin
        if (rst) begin
            cksum_ref <= '0;
            cksum_acc <= '0;
        end else if (bus.load_start) begin
            cksum_ref <= bus.cfg_cksum;
            cksum_acc <= '0;
        end else if (write_c) begin
            cksum_acc <= cksum_acc + 8'(bus.cfg_data);
        end
    end
`endif

    // Table RAM write: one beat fills EPB consecutive entries; contents survive reset
    always_ff @(posedge clk) begin
        if (write_c) begin
            for (int i = 0; i < int'(EPB); i++) begin
                mem[IN_BITS'(beat_cnt) * IN_BITS'(EPB) + IN_BITS'(i)] <=
                    bus.cfg_data[OUT_BITS*i +: OUT_BITS];
            end
        end
    end

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.loaded    = loaded_q;
    assign bus.load_err  = load_err_q;
    assign bus.M1_valid  = m1_valid_q;
    assign bus.M1        = m1_q;
endmodule

// File: tb/tb_lut_neuron_loader.sv
// Directed bench for lut_neuron_loader with a table scoreboard.
// Checksum tests run only when LUT_CKSUM_EN is defined.
module tb_lut_neuron_loader;
    localparam int unsigned IN_BITS  = 8;
    localparam int unsigned OUT_BITS = 2;
    localparam int unsigned CFG_W    = 8;
    localparam int unsigned NB       = 64;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [OUT_BITS-1:0] model [256];
    logic [7:0]          pat   [NB];

    lut_neuron_loader_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .CFG_W(CFG_W)) bus ();

    lut_neuron_loader #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .CFG_W(CFG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat_sum();
        logic [7:0] s;
        s = 8'h00;
        for (int k = 0; k < int'(NB); k++) s = s + pat[k];
        return s;
    endfunction

    task automatic set_cksum(input int delta);
`ifdef LUT_CKSUM_EN
        bus.cfg_cksum = pat_sum() + 8'(delta);
`else
        if (delta != 0) $display("note: checksum offset %0d ignored", delta);
`endif
    endtask

    task automatic fill_pat(input int mode);
        for (int k = 0; k < int'(NB); k++) begin
            if (mode == 0)      pat[k] = 8'b1110_0100;
            else if (mode == 1) pat[k] = 8'b0001_1011;
            else                pat[k] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic start_load();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    // Offer one beat, wait (bounded) for acceptance, and mirror it into the model
    task automatic send_beat(input int k, input logic [7:0] d, input logic last, input bit gaps);
        bit accepted;
        if (gaps) begin
            bus.cfg_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = d;
        bus.cfg_last  = last;
        accepted = 1'b0;
        for (int b = 0; b < 20 && !accepted; b++) begin
            if (bus.cfg_ready) begin
                accepted = 1'b1;
                for (int i = 0; i < 4; i++) model[k*4 + i] = d[2*i +: 2];
            end
            tick();
        end
        if (!accepted) begin
            checks++;
            failures++;
            $error("FAIL accept_timeout beat=%0d observed=%0d expected=%0d", k, 0, 1);
        end
        bus.cfg_valid = 1'b0;
        bus.cfg_last  = 1'b0;
    endtask

    task automatic send_beats(input int n, input int last_at, input bit gaps);
        for (int k = 0; k < n; k++) send_beat(k, pat[k], (k == last_at), gaps);
    endtask

    task automatic lookup(input logic [7:0] a);
        bus.M0_valid = 1'b1;
        bus.M0       = a;
        tick();
        bus.M0_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst            = 1'b1;
        bus.load_start = 1'b0;
        bus.cfg_valid  = 1'b0;
        bus.cfg_data   = '0;
        bus.cfg_last   = 1'b0;
        bus.M0_valid   = 1'b0;
        bus.M0         = '0;
`ifdef LUT_CKSUM_EN
        bus.cfg_cksum  = '0;
`endif
        repeat (3) tick();
        rst = 1'b0;

        // Reset state; lookups ignored while EMPTY
        check("rst_cfg_ready", 32'(bus.cfg_ready), 0);
        check("rst_loaded",    32'(bus.loaded),    0);
        check("rst_load_err",  32'(bus.load_err),  0);
        check("rst_m1_valid",  32'(bus.M1_valid),  0);
        check("rst_m1",        32'(bus.M1),        0);
        lookup(8'h00);
        check("empty_lookup_valid", 32'(bus.M1_valid), 0);
        check("empty_loaded",       32'(bus.loaded),   0);

        // Full load of 8'b11100100 -> entry = addr mod 4
        fill_pat(0);
        set_cksum(0);
        start_load();
        check("load_cfg_ready", 32'(bus.cfg_ready), 1);
        send_beats(64, 63, 1'b0);
        check("load1_loaded",    32'(bus.loaded),    1);
        check("load1_cfg_ready", 32'(bus.cfg_ready), 0);
        check("load1_err",       32'(bus.load_err),  0);
        lookup(8'd5);
        check("lk5_valid", 32'(bus.M1_valid), 1);
        check("lk5_m1",    32'(bus.M1),       32'h1);
        lookup(8'd255);
        check("lk255_valid", 32'(bus.M1_valid), 1);
        check("lk255_m1",    32'(bus.M1),       32'h3);
        tick();
        check("idle_valid", 32'(bus.M1_valid), 0);
        check("idle_m1_hold", 32'(bus.M1),     32'h3);

        // Early cfg_last on beat 10 -> error
        fill_pat(2);
        set_cksum(0);
        start_load();
        send_beats(11, 10, 1'b0);
        check("early_err",       32'(bus.load_err),  1);
        check("early_loaded",    32'(bus.loaded),    0);
        check("early_cfg_ready", 32'(bus.cfg_ready), 0);

        // Restart clears the error; load 8'b00011011 -> entry = 3 - (addr mod 4)
        fill_pat(1);
        set_cksum(0);
        start_load();
        check("restart_err",       32'(bus.load_err),  0);
        check("restart_cfg_ready", 32'(bus.cfg_ready), 1);
        send_beats(64, 63, 1'b0);
        check("load2_loaded", 32'(bus.loaded), 1);

        // Lookup with load_start in READY is served from the old table
        fill_pat(0);
        set_cksum(0);
        bus.load_start = 1'b1;
        bus.M0_valid   = 1'b1;
        bus.M0         = 8'd7;
        tick();
        bus.load_start = 1'b0;
        check("old_tbl_valid",  32'(bus.M1_valid),  1);
        check("old_tbl_m1",     32'(bus.M1),        32'h0);
        check("reload_loaded",  32'(bus.loaded),    0);
        check("reload_ready",   32'(bus.cfg_ready), 1);
        lookup(8'd7);
        check("loading_lk_valid", 32'(bus.M1_valid), 0);
        check("loading_lk_hold",  32'(bus.M1),       32'h0);
        send_beats(64, 63, 1'b0);
        check("load3_loaded", 32'(bus.loaded), 1);
        lookup(8'd7);
        check("new_tbl_valid", 32'(bus.M1_valid), 1);
        check("new_tbl_m1",    32'(bus.M1),       32'h3);

        // Missing cfg_last on beat 63 -> error
        fill_pat(2);
        set_cksum(0);
        start_load();
        send_beats(64, -1, 1'b0);
        check("nolast_err",    32'(bus.load_err), 1);
        check("nolast_loaded", 32'(bus.loaded),   0);

        // Gapped load interrupted by rst at beat 30
        fill_pat(2);
        set_cksum(0);
        start_load();
        send_beats(30, 63, 1'b1);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = pat[30];
        rst           = 1'b1;
        tick();
        rst           = 1'b0;
        check("midrst_cfg_ready", 32'(bus.cfg_ready), 0);
        check("midrst_loaded",    32'(bus.loaded),    0);
        tick();
        bus.cfg_valid = 1'b0;
        check("midrst_still_idle", 32'(bus.cfg_ready), 0);

        // Full gapped reload, then sweep every address against the model
        fill_pat(2);
        set_cksum(0);
        start_load();
        send_beats(64, 63, 1'b1);
        check("load4_loaded", 32'(bus.loaded), 1);
        for (int a = 0; a < 256; a++) begin
            lookup(8'(a));
            check($sformatf("sweep_%0d", a), 32'(bus.M1), 32'(model[a]));
        end

`ifdef LUT_CKSUM_EN
        // Checksum: correct value loads, off by one fails
        fill_pat(2);
        set_cksum(0);
        start_load();
        send_beats(64, 63, 1'b0);
        check("ck_ok_loaded", 32'(bus.loaded),   1);
        check("ck_ok_err",    32'(bus.load_err), 0);
        fill_pat(2);
        set_cksum(1);
        start_load();
        send_beats(64, 63, 1'b0);
        check("ck_bad_err",    32'(bus.load_err), 1);
        check("ck_bad_loaded", 32'(bus.loaded),   0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
